// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_READ combinational reads, two write ports (B wins on conflict),
// optional write-to-read bypass, hardwired-zero entry 0 and sequential or single-cycle clear.
module reg_file_mp #(
  parameter int WIDTH         = 32,
  parameter int WIDTH_ADD     = 5,
  parameter int NUM_REGISTERS = 32,
  parameter int NUM_READ      = 2,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1,
  parameter int SEQ_CLEAR     = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_req,
  input  logic                          we_a,
  input  logic [WIDTH_ADD-1:0]          wa_a,
  input  logic [WIDTH-1:0]              wd_a,
  input  logic                          we_b,
  input  logic [WIDTH_ADD-1:0]          wa_b,
  input  logic [WIDTH-1:0]              wd_b,
  input  logic [NUM_READ*WIDTH_ADD-1:0] rd_addr,
  output logic [NUM_READ*WIDTH-1:0]     rd_data,
  output logic                          busy
);

  localparam int PW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_REGISTERS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  clr_ptr_q, clr_ptr_d;
  logic           clr_en;
  logic           clr_all;
  logic           wr_ok;
  logic           wen_a, wen_b;
  logic [WIDTH-1:0] mem_q [NUM_REGISTERS];

  // Legal target: inside the array and not the hardwired-zero entry.
  function automatic logic addr_ok(input logic [WIDTH_ADD-1:0] a);
    return (int'(a) < NUM_REGISTERS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [PW-1:0] idx(input logic [WIDTH_ADD-1:0] a);
    return a[PW-1:0];
  endfunction

  // Writes are blocked while clearing and on the cycle a clear is being requested.
  assign wr_ok   = (state_q == IDLE) && !reset && !clear_req;
  assign wen_a   = wr_ok && we_a && addr_ok(wa_a);
  assign wen_b   = wr_ok && we_b && addr_ok(wa_b);
  assign clr_all = (SEQ_CLEAR == 0) && (reset || clear_req);
  assign busy    = (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_en    = 1'b0;
    if (SEQ_CLEAR != 0) begin
      if (state_q == IDLE) begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end else begin
        clr_en    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (SEQ_CLEAR != 0) ? CLEAR : IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // A reset edge during a sequential clear only rewinds the pointer; the entry is not touched.
  always_ff @(posedge clk) begin
    if (clr_all) begin
      for (int i = 0; i < NUM_REGISTERS; i++) mem_q[i] <= '0;
    end else begin
      if (clr_en && !reset) mem_q[clr_ptr_q] <= '0;
      if (wen_a) mem_q[idx(wa_a)] <= wd_a;
      if (wen_b) mem_q[idx(wa_b)] <= wd_b;
    end
  end

  always_comb begin
    logic [WIDTH_ADD-1:0] a;
    logic [WIDTH-1:0]     val;
    rd_data = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      a   = rd_addr[k*WIDTH_ADD +: WIDTH_ADD];
      val = '0;
      if ((state_q == IDLE) && addr_ok(a)) begin
        val = mem_q[idx(a)];
        if (BYPASS != 0) begin
          if (wen_b && (wa_b == a))      val = wd_b;
          else if (wen_a && (wa_a == a)) val = wd_a;
        end
      end
      rd_data[k*WIDTH +: WIDTH] = val;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a 32-entry bypassing sequential-clear instance and a 24-entry
// non-bypassing single-cycle-clear instance share stimulus and are checked against array models.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset, clear_req, we_a, we_b;
  logic [4:0]  wa_a, wa_b;
  logic [31:0] wd_a, wd_b;
  logic [9:0]  rd_addr;
  logic [63:0] rd1, rd2;
  logic        busy1, busy2;

  int checks = 0;
  int errors = 0;

  logic [31:0] m1 [32];
  logic [31:0] m2 [24];
  int          clr_left = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.WIDTH(32), .WIDTH_ADD(5), .NUM_REGISTERS(32), .NUM_READ(2),
                .ZERO_REG(1), .BYPASS(1), .SEQ_CLEAR(1)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rd_addr(rd_addr), .rd_data(rd1), .busy(busy1));

  reg_file_mp #(.WIDTH(32), .WIDTH_ADD(5), .NUM_REGISTERS(24), .NUM_READ(2),
                .ZERO_REG(1), .BYPASS(0), .SEQ_CLEAR(0)) dut2 (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .rd_addr(rd_addr), .rd_data(rd2), .busy(busy2));

  function automatic logic [31:0] exp1(input logic [4:0] a);
    if (clr_left > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we_b && wa_b == a) return wd_b;
    if (we_a && wa_a == a) return wd_a;
    return m1[a];
  endfunction

  function automatic logic [31:0] exp2(input logic [4:0] a);
    if (a == 5'd0 || a >= 5'd24) return 32'h0;
    return m2[a];
  endfunction

  function automatic logic [63:0] exp_rd1();
    return {exp1(rd_addr[9:5]), exp1(rd_addr[4:0])};
  endfunction

  function automatic logic [63:0] exp_rd2();
    return {exp2(rd_addr[9:5]), exp2(rd_addr[4:0])};
  endfunction

  task automatic idle_inputs();
    reset = 1'b0; clear_req = 1'b0;
    we_a = 1'b0; wa_a = 5'd0; wd_a = 32'h0;
    we_b = 1'b0; wa_b = 5'd0; wd_b = 32'h0;
    rd_addr = 10'd0;
  endtask

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic step();
    @(posedge clk);
    if (reset || (clear_req && clr_left == 0)) begin
      clr_left = 32;
      foreach (m1[i]) m1[i] = 32'h0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      if (we_a && wa_a != 5'd0) m1[wa_a] = wd_a;
      if (we_b && wa_b != 5'd0) m1[wa_b] = wd_b;
    end
    if (reset || clear_req) begin
      foreach (m2[i]) m2[i] = 32'h0;
    end else begin
      if (we_a && wa_a != 5'd0 && wa_a < 5'd24) m2[wa_a] = wd_a;
      if (we_b && wa_b != 5'd0 && wa_b < 5'd24) m2[wa_b] = wd_b;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_cycle_busy got %b exp 0", busy1); end
    step();
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      we_a = 1'b1; wa_a = 5'($urandom); wd_a = $urandom;
      we_b = 1'b1; wa_b = 5'($urandom); wd_b = $urandom;
      rd_addr = 10'($urandom);
      #1;
      if (busy1 !== 1'b1) break;
      n++;
      checks++;
      if (rd1 !== 64'h0) begin errors++; $display("FAIL clear_rd_zero got %h exp 0", rd1); end
      step();
    end
    idle_inputs();
    checks++;
    if (n != 32) begin errors++; $display("FAIL clear_busy_len got %0d exp 32", n); end
    for (int a = 0; a < 32; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      checks++;
      if (rd1 !== 64'h0) begin errors++; $display("FAIL after_clear_zero addr %0d got %h exp 0", a, rd1); end
      checks++;
      if (rd2 !== exp_rd2()) begin errors++; $display("FAIL after_clear_rd2 addr %0d got %h exp %h", a, rd2, exp_rd2()); end
      step();
    end
  endtask

  task automatic test_no_bypass();
    idle_inputs();
    we_b = 1'b1; wa_b = 5'd5; wd_b = 32'h0;
    step();
    idle_inputs();
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
    rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rd2[31:0] !== 32'h0) begin errors++; $display("FAIL nobyp_same_cycle got %h exp 0", rd2[31:0]); end
    checks++;
    if (rd1[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_same_cycle got %h exp deadbeef", rd1[31:0]); end
    step();
    we_a = 1'b0;
    #1;
    checks++;
    if (rd2[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL nobyp_next_cycle got %h exp deadbeef", rd2[31:0]); end
    checks++;
    if (rd1[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_next_cycle got %h exp deadbeef", rd1[31:0]); end
    step();
  endtask

  task automatic test_bypass_priority();
    idle_inputs();
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h11;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h22;
    rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rd1 !== {32'h22, 32'h22}) begin errors++; $display("FAIL prio_bypass got %h exp 22/22", rd1); end
    step();
    we_a = 1'b0; we_b = 1'b0;
    #1;
    checks++;
    if (rd1 !== {32'h22, 32'h22}) begin errors++; $display("FAIL prio_stored1 got %h exp 22/22", rd1); end
    checks++;
    if (rd2 !== {32'h22, 32'h22}) begin errors++; $display("FAIL prio_stored2 got %h exp 22/22", rd2); end
    step();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFFFFFF;
    we_b = 1'b1; wa_b = 5'd0; wd_b = 32'hFFFFFFFF;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd1 !== 64'h0) begin errors++; $display("FAIL zero_same_cycle got %h exp 0", rd1); end
    step();
    we_a = 1'b0; we_b = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rd1 !== 64'h0 || rd2 !== 64'h0) begin
        errors++; $display("FAIL zero_later got %h / %h exp 0", rd1, rd2);
      end
      step();
    end
  endtask

  task automatic test_out_of_range();
    idle_inputs();
    we_a = 1'b1; wa_a = 5'd30; wd_a = 32'hAB;
    rd_addr = {5'd30, 5'd30};
    #1;
    checks++;
    if (rd2 !== 64'h0) begin errors++; $display("FAIL oor_same_cycle got %h exp 0", rd2); end
    step();
    we_a = 1'b0;
    #1;
    checks++;
    if (rd2 !== 64'h0) begin errors++; $display("FAIL oor_read got %h exp 0", rd2); end
    checks++;
    if (rd1 !== {32'hAB, 32'hAB}) begin errors++; $display("FAIL inrange_32 got %h exp ab/ab", rd1); end
    step();
    for (int a = 0; a < 24; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      checks++;
      if (rd2 !== exp_rd2()) begin errors++; $display("FAIL oor_unchanged addr %0d got %h exp %h", a, rd2, exp_rd2()); end
      step();
    end
  endtask

  task automatic test_reset_during_clear();
    int n;
    idle_inputs();
    clear_req = 1'b1;
    #1;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL clrreq_cycle_busy got %b exp 0", busy1); end
    step();
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (busy1 !== 1'b1) begin errors++; $display("FAIL clrreq_busy cyc %0d got %b exp 1", c, busy1); end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      clear_req = (n == 5);
      #1;
      if (busy1 !== 1'b1) break;
      n++;
      checks++;
      if (rd1 !== 64'h0) begin errors++; $display("FAIL midclr_rd_zero got %h exp 0", rd1); end
      step();
    end
    clear_req = 1'b0;
    checks++;
    if (n != 32) begin errors++; $display("FAIL midclr_busy_len got %0d exp 32", n); end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = int'($urandom_range(0, 99));
      reset = (r == 0);
      clear_req = (r == 1);
      we_a = !(reset || clear_req) && $urandom_range(0, 1) == 1;
      we_b = !(reset || clear_req) && $urandom_range(0, 1) == 1;
      wa_a = 5'($urandom); wd_a = $urandom;
      wa_b = ($urandom_range(0, 3) == 0) ? wa_a : 5'($urandom);
      wd_b = $urandom;
      rd_addr[4:0] = ($urandom_range(0, 1) == 1) ? wa_b : 5'($urandom);
      rd_addr[9:5] = ($urandom_range(0, 1) == 1) ? wa_a : 5'($urandom);
      #1;
      checks++;
      if (rd1 !== exp_rd1()) begin errors++; $display("FAIL rand_rd1 cyc %0d got %h exp %h", c, rd1, exp_rd1()); end
      checks++;
      if (rd2 !== exp_rd2()) begin errors++; $display("FAIL rand_rd2 cyc %0d got %h exp %h", c, rd2, exp_rd2()); end
      checks++;
      if (busy1 !== (clr_left > 0) || busy2 !== 1'b0) begin
        errors++; $display("FAIL rand_busy cyc %0d got %b/%b exp %b/0", c, busy1, busy2, clr_left > 0);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    foreach (m1[i]) m1[i] = 32'h0;
    foreach (m2[i]) m2[i] = 32'h0;
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (32) step();
    test_reset();
    test_no_bypass();
    test_bypass_priority();
    test_zero_reg();
    test_out_of_range();
    test_reset_during_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
